// File: rtl/c_drain_ctrl.sv
// Readback sequencer: walks C addresses (outer) and result banks (inner),
// reads each 32-bit word and streams it MSB-first to the UART as four bytes.
module c_drain_ctrl #(
   parameter int N       = 2,
   parameter int C_AW    = 8,
   parameter int RAM_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [C_AW:0]       num_words,
   output logic [C_AW-1:0]     ram_c_addr,
   output logic [N*N-1:0]      ram_c_rden,
   input  logic [N*N*32-1:0]   ram_c_q,
   output logic [7:0]          tx_data,
   output logic                tx_send,
   input  logic                tx_done,
   output logic                busy,
   output logic                done
);
   localparam int NB = N * N;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int WW = (RAM_LAT > 2) ? $clog2(RAM_LAT - 1) : 1;
   localparam logic [WW-1:0]   WAIT_LAST = WW'((RAM_LAT > 1) ? RAM_LAT - 2 : 0);
   localparam logic [BW-1:0]   BANK_LAST = BW'(NB - 1);
   localparam logic [C_AW:0]   MAX_WORDS = {1'b1, {C_AW{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_LOAD, S_SEND, S_WAIT_TX, S_NEXT
   } state_t;

   state_t            r_state, w_state_next;
   logic [C_AW:0]     r_addr_cnt, w_addr_next;
   logic [BW-1:0]     r_bank, w_bank_next;
   logic [1:0]        r_byte, w_byte_next;
   logic [WW-1:0]     r_wait, w_wait_next;
   logic [31:0]       r_shreg, w_shreg_next;
   logic [C_AW:0]     r_nwords, w_nwords_next;

   logic [C_AW-1:0]   r_ram_c_addr, w_addr_o_next;
   logic [NB-1:0]     r_ram_c_rden, w_rden_next;
   logic [7:0]        r_tx_data, w_txd_next;
   logic              r_tx_send, w_send_next;
   logic              r_busy, w_busy_next;
   logic              r_done, w_done_next;

   logic [31:0]       w_words [NB];
   logic [31:0]       w_bank_word;
   logic [C_AW:0]     w_addr_inc;
   logic [C_AW:0]     w_nwords_clamped;

   for (genvar gi = 0; gi < NB; gi++) begin : g_bank
      assign w_words[gi] = ram_c_q[32*gi +: 32];
   end

   assign w_bank_word      = w_words[r_bank];
   assign w_addr_inc       = r_addr_cnt + (C_AW+1)'(1);
   // Requests beyond the RAM depth drain the whole RAM exactly once.
   assign w_nwords_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

   always_comb begin
      w_state_next  = r_state;
      w_addr_next   = r_addr_cnt;
      w_bank_next   = r_bank;
      w_byte_next   = r_byte;
      w_wait_next   = r_wait;
      w_shreg_next  = r_shreg;
      w_nwords_next = r_nwords;
      w_addr_o_next = r_ram_c_addr;
      w_rden_next   = '0;
      w_txd_next    = r_tx_data;
      w_send_next   = 1'b0;
      w_done_next   = 1'b0;
      w_busy_next   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (num_words == '0) begin
                  w_done_next = 1'b1;
               end else begin
                  w_nwords_next = w_nwords_clamped;
                  w_addr_next   = '0;
                  w_bank_next   = '0;
                  w_state_next  = S_READ;
               end
            end
         end
         S_READ: begin
            w_wait_next  = '0;
            w_state_next = (RAM_LAT > 1) ? S_WAIT : S_LOAD;
         end
         S_WAIT: begin
            if (r_wait == WAIT_LAST) w_state_next = S_LOAD;
            else                     w_wait_next  = r_wait + WW'(1);
         end
         S_LOAD: begin
            w_shreg_next = w_bank_word;
            w_byte_next  = '0;
            w_state_next = S_SEND;
         end
         S_SEND: begin
            w_state_next = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (tx_done) begin
               if (r_byte == 2'd3) begin
                  w_state_next = S_NEXT;
               end else begin
                  w_byte_next  = r_byte + 2'd1;
                  w_shreg_next = {r_shreg[23:0], 8'h00};
                  w_state_next = S_SEND;
               end
            end
         end
         S_NEXT: begin
            if (r_bank == BANK_LAST) begin
               w_bank_next = '0;
               if (w_addr_inc < r_nwords) begin
                  w_addr_next  = w_addr_inc;
                  w_state_next = S_READ;
               end else begin
                  w_addr_next  = '0;
                  w_done_next  = 1'b1;
                  w_state_next = S_IDLE;
               end
            end else begin
               w_bank_next  = r_bank + BW'(1);
               w_state_next = S_READ;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      if (w_state_next == S_READ) begin
         w_addr_o_next = w_addr_next[C_AW-1:0];
         w_rden_next   = NB'(1) << w_bank_next;
      end
      if (w_state_next == S_SEND) begin
         w_send_next = 1'b1;
         w_txd_next  = w_shreg_next[31:24];
      end
      w_busy_next = (w_state_next != S_IDLE);

      if (abort) begin
         w_state_next  = S_IDLE;
         w_addr_next   = '0;
         w_bank_next   = '0;
         w_byte_next   = '0;
         w_wait_next   = '0;
         w_shreg_next  = '0;
         w_nwords_next = '0;
         w_addr_o_next = '0;
         w_rden_next   = '0;
         w_txd_next    = '0;
         w_send_next   = 1'b0;
         w_done_next   = 1'b0;
         w_busy_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_addr_cnt   <= '0;
         r_bank       <= '0;
         r_byte       <= '0;
         r_wait       <= '0;
         r_shreg      <= '0;
         r_nwords     <= '0;
         r_ram_c_addr <= '0;
         r_ram_c_rden <= '0;
         r_tx_data    <= '0;
         r_tx_send    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_addr_cnt   <= w_addr_next;
         r_bank       <= w_bank_next;
         r_byte       <= w_byte_next;
         r_wait       <= w_wait_next;
         r_shreg      <= w_shreg_next;
         r_nwords     <= w_nwords_next;
         r_ram_c_addr <= w_addr_o_next;
         r_ram_c_rden <= w_rden_next;
         r_tx_data    <= w_txd_next;
         r_tx_send    <= w_send_next;
         r_busy       <= w_busy_next;
         r_done       <= w_done_next;
      end
   end

   assign ram_c_addr = r_ram_c_addr;
   assign ram_c_rden = r_ram_c_rden;
   assign tx_data    = r_tx_data;
   assign tx_send    = r_tx_send;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_c_drain_ctrl.sv
// Bench for c_drain_ctrl: RAM and UART models, table of drain scenarios,
// plus hand-written abort and mid-word reset sequences.
module tb_c_drain_ctrl;
   localparam int N       = 2;
   localparam int C_AW    = 8;
   localparam int RAM_LAT = 2;
   localparam int NB      = N * N;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              tx_done = 1'b0;
   logic [C_AW:0]     num_words = '0;
   logic [NB*32-1:0]  ram_c_q = '0;
   logic [C_AW-1:0]   ram_c_addr;
   logic [NB-1:0]     ram_c_rden;
   logic [7:0]        tx_data;
   logic              tx_send;
   logic              busy;
   logic              done;

   c_drain_ctrl #(.N(N), .C_AW(C_AW), .RAM_LAT(RAM_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
      .ram_c_addr(ram_c_addr), .ram_c_rden(ram_c_rden), .ram_c_q(ram_c_q),
      .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [C_AW:0] nw;
      int            mode;
      bit            stray;
      int            lat;
      int            exp_sends;
      int            exp_last_addr;
   } scen_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   mode = 0;
   int   uart_lat = 10;
   bit   stray_en = 1'b0;

   logic [7:0]    got_b[$];
   int            got_a[$];
   logic [NB-1:0] got_r[$];
   int   onehot_err, done_cnt, done_cyc, first_send_cyc, last_txdone_cyc, busy_first_cyc;
   logic busy_at_done;

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int m, input int k, input int a);
      logic [31:0] w;
      if (m == 0) begin
         case (k)
            0:       w = 32'h3F80_0000;
            1:       w = 32'h4000_0000;
            2:       w = 32'h4040_0000;
            default: w = 32'h4080_0000;
         endcase
      end else begin
         w = {a[15:0], k[15:0]};
      end
      return w;
   endfunction

   // RAM with RAM_LAT=2: address stage register then data register.
   logic [C_AW-1:0] s_addr, p1_addr = '0;
   logic [NB-1:0]   s_en, p1_en = '0;
   initial forever begin
      @(negedge clk);
      s_addr = ram_c_addr;
      s_en   = ram_c_rden;
      @(posedge clk);
      for (int k = 0; k < NB; k++)
         if (p1_en[k] === 1'b1) ram_c_q[32*k +: 32] <= model_word(mode, k, int'(p1_addr));
      p1_addr = s_addr;
      p1_en   = s_en;
   end

   // UART: tx_done uart_lat cycles after each send; stray mode adds a pulse
   // coincident with tx_send.
   initial forever begin
      if (tx_send === 1'b1) begin
         if (stray_en && uart_lat > 1) begin
            tx_done = 1'b1; step(); tx_done = 1'b0;
            repeat (uart_lat - 1) step();
         end else begin
            repeat (uart_lat) step();
         end
         tx_done = 1'b1; step(); tx_done = 1'b0;
      end else begin
         step();
      end
   end

   // Stray injector: tx_done and start pulses while the DUT is in READ.
   initial forever begin
      step();
      if (stray_en && ram_c_rden != '0) begin
         tx_done = 1'b1; start = 1'b1; num_words = 9'd3;
         step();
         tx_done = 1'b0; start = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (ram_c_rden != '0 && !$isunknown(ram_c_rden)) begin
         got_r.push_back(ram_c_rden);
         if (!$onehot(ram_c_rden)) onehot_err++;
      end
      if (tx_send === 1'b1) begin
         if (got_b.size() == 0) first_send_cyc = cyc;
         got_b.push_back(tx_data);
         got_a.push_back(int'(ram_c_addr));
      end
      if (tx_done === 1'b1) last_txdone_cyc = cyc;
      if (busy === 1'b1 && busy_first_cyc < 0) busy_first_cyc = cyc;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
   end

   task automatic clear_mon();
      got_b.delete(); got_a.delete(); got_r.delete();
      onehot_err = 0; done_cnt = 0; done_cyc = -1; first_send_cyc = -1;
      last_txdone_cyc = -1; busy_first_cyc = -1; busy_at_done = 1'b0;
   endtask

   task automatic run_scen(input string tag, input scen_t s);
      logic [7:0]    exp_b[$];
      int            exp_a[$];
      logic [NB-1:0] exp_r[$];
      logic [31:0]   w;
      int            eff, t, nb, nr;
      clear_mon();
      eff = (int'(s.nw) > 256) ? 256 : int'(s.nw);
      for (int a = 0; a < eff; a++)
         for (int k = 0; k < NB; k++) begin
            w = model_word(s.mode, k, a);
            exp_r.push_back(NB'(1) << k);
            for (int b = 0; b < 4; b++) begin
               exp_b.push_back(w[31-8*b -: 8]);
               exp_a.push_back(a);
            end
         end
      mode = s.mode; uart_lat = s.lat; stray_en = s.stray;
      num_words = s.nw; start = 1'b1; t = cyc;
      step();
      start = 1'b0;
      for (int c = 0; c < 300 * eff + 100 && done_cnt == 0; c++) step();
      stray_en = 1'b0;
      repeat (20) step();
      check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
      check({tag, "_send_count"}, 64'(got_b.size()), 64'(s.exp_sends));
      check({tag, "_rden_count"}, 64'(got_r.size()), 64'(exp_r.size()));
      check({tag, "_onehot_err"}, 64'(onehot_err), 64'(0));
      check({tag, "_last_addr"}, 64'(ram_c_addr), 64'(s.exp_last_addr));
      nb = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
      for (int i = 0; i < nb; i++) begin
         check($sformatf("%s_byte%0d", tag, i), 64'(got_b[i]), 64'(exp_b[i]));
         check($sformatf("%s_addr%0d", tag, i), 64'(got_a[i]), 64'(exp_a[i]));
      end
      nr = (got_r.size() < exp_r.size()) ? got_r.size() : exp_r.size();
      for (int i = 0; i < nr; i++)
         check($sformatf("%s_rden%0d", tag, i), 64'(got_r[i]), 64'(exp_r[i]));
      if (eff > 0) begin
         check({tag, "_busy_rise"}, 64'(busy_first_cyc - t), 64'(1));
         check({tag, "_first_send"}, 64'(first_send_cyc - t), 64'(2 + RAM_LAT));
         check({tag, "_done_lat"}, 64'(done_cyc - last_txdone_cyc), 64'(2));
         check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'(0));
      end else begin
         check({tag, "_done_lat"}, 64'(done_cyc - t), 64'(1));
         check({tag, "_busy_never"}, 64'(busy_first_cyc), 64'(-1));
      end
      $display("scenario %s: nw=%0d bytes=%0d dones=%0d", tag, s.nw, got_b.size(), done_cnt);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},    64'(ram_c_addr), 64'(0));
      check({tag, "_rden"},    64'(ram_c_rden), 64'(0));
      check({tag, "_tx_data"}, 64'(tx_data),    64'(0));
      check({tag, "_tx_send"}, 64'(tx_send),    64'(0));
      check({tag, "_busy"},    64'(busy),       64'(0));
      check({tag, "_done"},    64'(done),       64'(0));
   endtask

   scen_t tbl[6];
   scen_t restart_s;

   initial begin
      tbl[0] = '{9'd1,   0, 1'b0, 10, 16,   0};
      tbl[1] = '{9'd3,   1, 1'b0, 10, 48,   2};
      tbl[2] = '{9'd0,   0, 1'b0, 10, 0,    2};
      tbl[3] = '{9'd1,   0, 1'b1, 10, 16,   0};
      tbl[4] = '{9'd256, 1, 1'b0, 1,  4096, 255};
      tbl[5] = '{9'd511, 1, 1'b0, 1,  4096, 255};
      restart_s = '{9'd1, 0, 1'b0, 10, 16, 0};
      clear_mon();

      repeat (3) step();
      check_reset_outputs("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_scen($sformatf("tbl%0d", i), tbl[i]);

      // abort and start in the same IDLE cycle
      clear_mon();
      num_words = 9'd1; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", 64'(busy), 64'(0));
      repeat (8) step();
      check("abort_start_rden", 64'(got_r.size()), 64'(0));
      check("abort_start_done", 64'(done_cnt), 64'(0));
      $display("sequence abort+start: busy=%0d reads=%0d", busy, got_r.size());

      // abort after the 6th tx_send
      clear_mon();
      mode = 0; uart_lat = 10; num_words = 9'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 400 && got_b.size() < 6; c++) step();
      check("abort_reach6", 64'(got_b.size()), 64'(6));
      check("abort_busy_before", 64'(busy), 64'(1));
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_reset_outputs("abort");
      repeat (40) step();
      check("abort_no_more_sends", 64'(got_b.size()), 64'(6));
      check("abort_no_done", 64'(done_cnt), 64'(0));
      $display("sequence abort: bytes=%0d dones=%0d", got_b.size(), done_cnt);
      run_scen("restart", restart_s);

      // synchronous reset in the middle of a word
      clear_mon();
      mode = 0; uart_lat = 10; num_words = 9'd2; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 400 && got_b.size() < 2; c++) step();
      check("rst_reach2", 64'(got_b.size()), 64'(2));
      check("rst_txdata_before", 64'(tx_data), 64'(8'h80));
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("midrst");
      repeat (40) step();
      check("midrst_no_more_sends", 64'(got_b.size()), 64'(2));
      check("midrst_no_done", 64'(done_cnt), 64'(0));
      $display("sequence mid-word reset: bytes=%0d dones=%0d", got_b.size(), done_cnt);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
